uart_tx_fifo: RTL

- Byte buffer placed directly upstream of UartTx.
- Accepts bursts of bytes from a producer at clock rate and stores them in a circular FIFO.
- Issues one-cycle write strobes to UartTx, one byte at a time, pacing on UartTx's ready output.
- Removes the need for producers to poll ready between bytes.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo_core.sv | 74 +++++++
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer.
package uart_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned DEPTH_LOG_DEF = 4;

    // Transmit FSM encodings
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle     = IDLE,
        StIssue    = ISSUE,
        StWaitBusy = WAIT_BUSY,
        StWaitDone = WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/sync_fifo_core.sv
// Generic circular FIFO: memory, pointers and occupancy count.
// Full/empty come from the count alone; pointers wrap with no extra bit.
module sync_fifo_core
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = DEPTH_LOG_DEF,
    parameter int unsigned WIDTH     = BYTE_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_pop,
    output logic [WIDTH-1:0]     o_rdata,
    output logic [DEPTH_LOG:0]   o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned        DEPTH    = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wr_ptr;
    logic [DEPTH_LOG-1:0] r_rd_ptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 r_full;

    logic                 w_push;
    logic                 w_pop;
    logic [DEPTH_LOG:0]   w_count_nxt;

    // Requests are qualified by the pre-edge occupancy
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && (r_count != '0);

    // Next occupancy from the qualified push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers, count and registered full flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer in front of UartTx: absorbs producer bursts and hands bytes
// to UartTx one at a time, pacing on its ready output.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = DEPTH_LOG_DEF,
    parameter int unsigned BUSY_WAIT = 2
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic [BYTE_W-1:0]    IN_DATA,
    input  logic                 IN_WE,
    output logic                 IN_FULL,
    output logic [BYTE_W-1:0]    OUT_DATA,
    output logic                 OUT_WE,
    input  logic                 OUT_READY,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic                 OVERFLOW
);

    localparam int unsigned BW        = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);
    localparam logic [BW-1:0] BUSY_LOAD = BW'(BUSY_WAIT);

    tx_state_e          r_state;
    tx_state_e          w_state_nxt;
    logic [BW-1:0]      r_busy;
    logic [BW-1:0]      w_busy_nxt;
    logic               r_out_we;
    logic               w_out_we_nxt;
    logic [BYTE_W-1:0]  r_out_data;
    logic [BYTE_W-1:0]  w_out_data_nxt;
    logic               r_overflow;

    logic [BYTE_W-1:0]  w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;

    sync_fifo_core #(
        .DEPTH_LOG (DEPTH_LOG),
        .WIDTH     (BYTE_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_X),
        .i_push  (IN_WE),
        .i_wdata (IN_DATA),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (COUNT),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pop coincides with the edge that raises OUT_WE
    assign w_pop = (r_state == StIdle) && !w_empty && OUT_READY;

    // Next state, strobe, data and busy-window counter.
    // The busy window starts at the strobe and also covers the ISSUE cycle,
    // so with ready held high strobes are 2+BUSY_WAIT cycles apart.
    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_out_we_nxt   = 1'b0;
        w_out_data_nxt = r_out_data;
        unique case (r_state)
            StIdle: begin
                if (w_pop) begin
                    w_state_nxt    = StIssue;
                    w_out_we_nxt   = 1'b1;
                    w_out_data_nxt = w_rdata;
                    w_busy_nxt     = BUSY_LOAD;
                end
            end
            StIssue: begin
                w_state_nxt = StWaitBusy;
                w_busy_nxt  = (r_busy != '0) ? r_busy - 1'b1 : '0;
            end
            StWaitBusy: begin
                if (!OUT_READY || (r_busy <= BW'(1))) begin
                    w_state_nxt = StWaitDone;
                    w_busy_nxt  = '0;
                end else begin
                    w_busy_nxt  = r_busy - 1'b1;
                end
            end
            StWaitDone: begin
                if (OUT_READY) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM and output registers
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state    <= StIdle;
            r_busy     <= '0;
            r_out_we   <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_out_we   <= w_out_we_nxt;
            r_out_data <= w_out_data_nxt;
        end
    end

    // Sticky overflow: a write arriving while full is dropped even if a pop
    // happens on the same edge
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_overflow <= 1'b0;
        end else if (IN_WE && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign IN_FULL  = w_full;
    assign OUT_WE   = r_out_we;
    assign OUT_DATA = r_out_data;
    assign OVERFLOW = r_overflow;

endmodule
